// File: rtl/dcache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_mem_ctrl
//
// Miss/eviction controller between the set-associative data cache and a
// word-wide main memory. On a miss it optionally writes the dirty victim line
// back, beat by beat, then fetches the missing line as sequential word beats.
// The assembled line is returned to the cache with a one-cycle response pulse.
//
// Ports:
//   clk                 system clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   i_cache_miss        miss request level, held until the response is seen
//   i_miss_addr         byte address of the missing access
//   i_evict             victim line is dirty (qualified by i_cache_miss)
//   i_evict_addr        byte address of the victim line
//   i_evict_data        victim line data
//   o_memory_line       refilled line, valid while o_memory_response is high
//   o_memory_response   one-cycle refill-complete pulse
//   o_busy              high in every state except idle
//   o_mem_req           beat request to memory
//   o_mem_we            1 = write beat, 0 = read beat
//   o_mem_addr          word-aligned beat address
//   o_mem_wdata         write beat data
//   i_mem_ready         memory accepts the request this cycle
//   i_mem_rvalid        read data valid
//   i_mem_rdata         read beat data
// -----------------------------------------------------------------------------
module dcache_mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cache_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              i_evict,
    input  logic [ADDR_W-1:0] i_evict_addr,
    input  logic [LINE_W-1:0] i_evict_data,
    output logic [LINE_W-1:0] o_memory_line,
    output logic              o_memory_response,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [WORD_W-1:0] i_mem_rdata
);

    localparam int unsigned BEATS       = LINE_W / WORD_W;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W       = $clog2(BEATS);
    localparam int unsigned BYTE_SH     = $clog2(WORD_W / 8);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StReadReq,
        StReadWait,
        StRespond
    } state_e;

    state_e                        r_state, w_state_d;
    logic [CNT_W-1:0]              r_k, w_k_d;
    logic [ADDR_W-1:0]             r_miss_base, w_miss_base_d;
    logic [ADDR_W-1:0]             r_evict_base, w_evict_base_d;
    logic [BEATS-1:0][WORD_W-1:0]  r_evict_data, w_evict_data_d;
    logic [BEATS-1:0][WORD_W-1:0]  r_line;

    logic                          r_mem_req, w_mem_req_d;
    logic                          r_mem_we, w_mem_we_d;
    logic [ADDR_W-1:0]             r_mem_addr, w_mem_addr_d;
    logic [WORD_W-1:0]             r_mem_wdata, w_mem_wdata_d;
    logic                          r_resp, w_resp_d;
    logic                          r_busy, w_busy_d;

    logic                          w_accept;
    logic                          w_rd_beat;
    logic                          w_last;

    assign w_accept  = r_mem_req & i_mem_ready;
    // rvalid is only meaningful while a read is outstanding
    assign w_rd_beat = (r_state == StReadWait) & i_mem_rvalid;
    assign w_last    = (r_k == LAST_BEAT);

    // State register and captured transfer context
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_k          <= '0;
            r_miss_base  <= '0;
            r_evict_base <= '0;
            r_evict_data <= '0;
        end else begin
            r_state      <= w_state_d;
            r_k          <= w_k_d;
            r_miss_base  <= w_miss_base_d;
            r_evict_base <= w_evict_base_d;
            r_evict_data <= w_evict_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d      = r_state;
        w_k_d          = r_k;
        w_miss_base_d  = r_miss_base;
        w_evict_base_d = r_evict_base;
        w_evict_data_d = r_evict_data;
        case (r_state)
            StIdle: begin
                if (i_cache_miss) begin
                    w_miss_base_d = i_miss_addr & LINE_MASK;
                    w_k_d         = '0;
                    if (i_evict) begin
                        w_evict_base_d = i_evict_addr & LINE_MASK;
                        w_evict_data_d = i_evict_data;
                        w_state_d      = StWb;
                    end else begin
                        w_state_d = StReadReq;
                    end
                end
            end
            StWb: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_k_d     = '0;
                        w_state_d = StReadReq;
                    end else begin
                        w_k_d = r_k + CNT_W'(1);
                    end
                end
            end
            StReadReq: begin
                if (w_accept) begin
                    w_state_d = StReadWait;
                end
            end
            StReadWait: begin
                if (w_rd_beat) begin
                    if (w_last) begin
                        w_state_d = StRespond;
                    end else begin
                        w_k_d     = r_k + CNT_W'(1);
                        w_state_d = StReadReq;
                    end
                end
            end
            StRespond: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output logic: computed from the next state so the registered request
    // appears in the same cycle the FSM enters a requesting state and stays
    // unchanged until the beat is accepted.
    always_comb begin
        w_mem_req_d   = (w_state_d == StWb) || (w_state_d == StReadReq);
        w_mem_we_d    = (w_state_d == StWb);
        w_mem_addr_d  = ((w_state_d == StWb) ? w_evict_base_d : w_miss_base_d)
                        + (ADDR_W'(w_k_d) << BYTE_SH);
        w_mem_wdata_d = w_mem_we_d ? w_evict_data_d[w_k_d] : '0;
        w_resp_d      = (w_state_d == StRespond);
        w_busy_d      = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_resp      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_resp      <= w_resp_d;
            r_busy      <= w_busy_d;
        end
    end

    // Line buffer keeps its contents after the response until the next refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
        end else if (w_rd_beat) begin
            r_line[r_k] <= i_mem_rdata;
        end
    end

    assign o_memory_line     = r_line;
    assign o_memory_response = r_resp;
    assign o_busy            = r_busy;
    assign o_mem_req         = r_mem_req;
    assign o_mem_we          = r_mem_we;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_ctrl
//
// Self-checking bench for dcache_mem_ctrl. A behavioural memory model answers
// beat requests (with configurable or random backpressure and read latency)
// and checks every accepted beat against an expected beat list built from the
// miss/evict addresses. Refilled lines are compared with words computed from
// the memory contents function.
// -----------------------------------------------------------------------------
module tb_dcache_mem_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_cache_miss = 1'b0;
    logic [31:0]  i_miss_addr = '0;
    logic         i_evict = 1'b0;
    logic [31:0]  i_evict_addr = '0;
    logic [511:0] i_evict_data = '0;
    logic [511:0] o_memory_line;
    logic         o_memory_response;
    logic         o_busy;
    logic         o_mem_req;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_ready = 1'b0;
    logic         i_mem_rvalid = 1'b0;
    logic [31:0]  i_mem_rdata = '0;

    dcache_mem_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_cache_miss      (i_cache_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy),
        .o_mem_req         (o_mem_req),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_ready       (i_mem_ready),
        .i_mem_rvalid      (i_mem_rvalid),
        .i_mem_rdata       (i_mem_rdata)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_resp  = 0;
    int n_done  = 0;
    int n_extra = 0;
    int rd_acc  = 0;
    int cyc     = 0;

    // Memory model configuration
    logic [31:0] salt       = '0;
    int          stall_n    = 0;
    bit          stall_rand = 1'b0;
    int          rd_delay   = 1;
    bit          rd_rand    = 1'b0;

    // Memory model state
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = '0;
    bit          held_v    = 1'b0;
    logic        h_we      = 1'b0;
    logic [31:0] h_addr    = '0;
    logic [31:0] h_data    = '0;
    int          wait_left = 0;
    beat_t       rb;

    beat_t        exp_q[$];
    logic [511:0] exp_line = '0;
    int           miss_cyc = 0;
    int           resp0    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Main memory contents: every word is its own address mixed with a salt
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Memory responder: ready/rvalid generation and beat checking
    always @(negedge clk) begin
        if (o_memory_response) n_resp++;
        if (!rst) begin
            pend_cnt     = 0;
            held_v       = 1'b0;
            wait_left    = 0;
            i_mem_ready  = 1'b0;
            i_mem_rvalid = 1'b0;
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = mem_word(pend_addr);
                end
            end else if ((!o_busy || (o_mem_req && o_mem_we)) && $urandom_range(0, 3) == 0) begin
                // Stray rvalid while no read is outstanding must be ignored
                i_mem_rvalid = 1'b1;
            end

            if (o_mem_req) begin
                if (!held_v) begin
                    held_v    = 1'b1;
                    h_we      = o_mem_we;
                    h_addr    = o_mem_addr;
                    h_data    = o_mem_wdata;
                    wait_left = stall_rand ? int'($urandom_range(0, 3)) : stall_n;
                end else begin
                    check("hold_we", o_mem_we, h_we);
                    check("hold_addr", o_mem_addr, h_addr);
                    check("hold_wdata", o_mem_wdata, h_data);
                end
                if (wait_left == 0) begin
                    i_mem_ready = 1'b1;
                    held_v      = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_extra++;
                    end else begin
                        rb = exp_q.pop_front();
                        check("beat_we", o_mem_we, rb.we);
                        check("beat_addr", o_mem_addr, rb.addr);
                        if (rb.we) check("beat_wdata", o_mem_wdata, rb.data);
                    end
                    if (!o_mem_we) begin
                        rd_acc++;
                        pend_addr = o_mem_addr;
                        pend_cnt  = rd_rand ? int'($urandom_range(1, 6)) : rd_delay;
                    end
                end else begin
                    i_mem_ready = 1'b0;
                    wait_left--;
                end
            end else begin
                held_v      = 1'b0;
                i_mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Call at a negedge with the controller idle
    task automatic start_miss(input logic [31:0] maddr, input logic ev,
                              input logic [31:0] eaddr, input logic [511:0] edata);
        logic [31:0] mb;
        logic [31:0] eb;
        beat_t       b;
        mb = maddr & 32'hFFFF_FFC0;
        eb = eaddr & 32'hFFFF_FFC0;
        if (ev) begin
            for (int k = 0; k < 16; k++) begin
                b.we   = 1'b1;
                b.addr = eb + 32'(4 * k);
                b.data = edata[32*k +: 32];
                exp_q.push_back(b);
            end
        end
        for (int k = 0; k < 16; k++) begin
            b.we   = 1'b0;
            b.addr = mb + 32'(4 * k);
            b.data = '0;
            exp_q.push_back(b);
            exp_line[32*k +: 32] = mem_word(mb + 32'(4 * k));
        end
        i_cache_miss = 1'b1;
        i_miss_addr  = maddr;
        i_evict      = ev;
        i_evict_addr = eaddr;
        i_evict_data = edata;
        miss_cyc     = cyc;
        resp0        = n_resp;
    endtask

    // Latency counts cycles from the one presenting the miss to the response
    // cycle, both inclusive; exp_lat = 0 skips the latency check.
    task automatic finish_miss(input int exp_lat);
        int guard;
        @(negedge clk);
        check("start_busy", o_busy, 1'b1);
        check("start_req", o_mem_req, 1'b1);
        // Cache-side inputs are don't-care once the miss is taken
        i_miss_addr  = $urandom;
        i_evict      = 1'($urandom);
        i_evict_addr = $urandom;
        i_evict_data = rand_line();
        guard = 0;
        while (!o_memory_response && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("resp_seen", o_memory_response, 1'b1);
        if (o_memory_response) begin
            n_done++;
            check("line", o_memory_line, exp_line);
            if (exp_lat > 0) check("latency", cyc - miss_cyc + 1, exp_lat);
            check("beats_left", exp_q.size(), 0);
            i_cache_miss = 1'b0;
            i_evict      = 1'b0;
            @(negedge clk);
            check("resp_width", o_memory_response, 1'b0);
            check("line_hold", o_memory_line, exp_line);
            check("resp_count", n_resp - resp0, 1);
        end else begin
            exp_q.delete();
            i_cache_miss = 1'b0;
            i_evict      = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] ed;
        int           rd0;
        int           r0;
        int           guard;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_req", o_mem_req, 1'b0);
        check("rst_we", o_mem_we, 1'b0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_wdata", o_mem_wdata, 32'h0);
        check("rst_resp", o_memory_response, 1'b0);
        check("rst_line", o_memory_line, 512'h0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Clean miss, zero-wait memory, data = beat address
        salt = '0; stall_rand = 1'b0; stall_n = 0; rd_rand = 1'b0; rd_delay = 1;
        start_miss(32'h0000_1234, 1'b0, 32'h0, '0);
        finish_miss(34);
        check("clean_lo", o_memory_line[31:0], 32'h0000_1200);
        check("clean_hi", o_memory_line[511:480], 32'h0000_123C);

        // Dirty miss: full writeback precedes the refill
        for (int k = 0; k < 16; k++) ed[32*k +: 32] = 32'hA500_0000 + 32'(k);
        start_miss(32'h0000_0100, 1'b1, 32'h0000_8040, ed);
        finish_miss(50);

        // Backpressure: 3 stall cycles per beat, read data 5 cycles late
        stall_n = 3; rd_delay = 5; salt = $urandom;
        start_miss(32'h0000_5678, 1'b0, 32'h0, '0);
        finish_miss(0);
        start_miss(32'h0001_0A04, 1'b1, 32'h0000_9F3C, rand_line());
        finish_miss(0);

        // Reset while waiting for read beat 7
        stall_n = 0; rd_delay = 12;
        rd0 = rd_acc;
        start_miss(32'h0000_4440, 1'b0, 32'h0, '0);
        guard = 0;
        while (rd_acc - rd0 < 8 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("rw7_busy", o_busy, 1'b1);
        check("rw7_req", o_mem_req, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_req", o_mem_req, 1'b0);
        check("abort_resp", o_memory_response, 1'b0);
        check("abort_line", o_memory_line, 512'h0);
        check("abort_addr", o_mem_addr, 32'h0);
        i_cache_miss = 1'b0;
        exp_q.delete();
        r0 = n_resp;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", o_busy, 1'b0);
        check("abort_noresp", n_resp - r0, 0);
        rd_delay = 1; salt = $urandom;
        start_miss(32'h0000_4440, 1'b0, 32'h0, '0);
        finish_miss(34);

        // Back-to-back misses
        r0 = n_resp;
        start_miss(32'h0000_2000, 1'b0, 32'h0, '0);
        finish_miss(34);
        start_miss(32'h0000_3000, 1'b0, 32'h0, '0);
        finish_miss(34);
        check("b2b_pulses", n_resp - r0, 2);

        // Evict without a miss is ignored
        i_evict      = 1'b1;
        i_evict_addr = $urandom;
        i_evict_data = rand_line();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("evnm_req", o_mem_req, 1'b0);
            check("evnm_busy", o_busy, 1'b0);
        end
        i_evict = 1'b0;

        // Random traffic
        stall_rand = 1'b1; rd_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            salt = $urandom;
            start_miss($urandom, 1'($urandom), $urandom, rand_line());
            finish_miss(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("extra_beats", n_extra, 0);
        check("resp_total", n_resp, n_done);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
